// File: rtl/phase5_verify_pkg.sv
// Shared types and helpers for the phase-5 time-lock verifier.
package phase5_verify_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRACK,
    LOCKOUT,
    UNLOCKED,
    ALARM
  } state_t;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W1     = 2'b01;
  localparam logic [1:0] W2     = 2'b10;
  localparam logic [1:0] W3     = 2'b11;

  // Key expected in window `win`; window k lives in seq[2k-1:2k-2].
  function automatic logic [1:0] expected_key(input logic [1:0] win,
                                              input logic [5:0] seq);
    case (win)
      W1:      return seq[1:0];
      W2:      return seq[3:2];
      W3:      return seq[5:4];
      default: return 2'b00;
    endcase
  endfunction

  // One-hot hit bit for a window code (bit k-1 for window k).
  function automatic logic [2:0] win_mask(input logic [1:0] win);
    case (win)
      W1:      return 3'b001;
      W2:      return 3'b010;
      W3:      return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/phase5_lockout_timer.sv
// Cooldown down-counter: load to LOCKOUT_CYCLES-1, step down to zero.
module phase5_lockout_timer #(
  parameter  int LOCKOUT_CYCLES = 16,
  localparam int CW             = $clog2(LOCKOUT_CYCLES) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic          i_dec,
  output logic          o_zero,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_count;

  // Load wins over decrement; counter parks at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    r_count <= '0;
    else if (i_load)                 r_count <= CW'(LOCKOUT_CYCLES - 1);
    else if (i_dec && r_count != '0) r_count <= r_count - 1'b1;
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/phase5_time_lock_verifier.sv
// Checks one correct key per sequencer window; unlocks, locks out or alarms.
module phase5_time_lock_verifier
  import phase5_verify_pkg::*;
#(
  parameter int         MAX_ATTEMPTS   = 3,
  parameter int         LOCKOUT_CYCLES = 16,
  parameter logic [5:0] EXPECT_SEQ     = 6'b10_01_11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] time_lock_out,
  input  logic       phase5_done,
  input  logic       phase5_fail,
  input  logic       key_valid,
  input  logic [1:0] key_code,
  output logic       key_ready,
  output logic [2:0] window_hit,
  output logic [2:0] attempts_left,
  output logic       locked_out,
  output logic       unlock,
  output logic       alarm
);

  localparam int CW = $clog2(LOCKOUT_CYCLES) + 1;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_prev_win;
  logic          r_key_seen, w_key_seen_nxt;
  logic [2:0]    r_hit, w_hit_nxt;
  logic [2:0]    r_att, w_att_nxt;
  logic          r_key_ready, r_locked_out, r_unlock, r_alarm;
  logic          w_load, w_dec, w_zero, w_fail_att;
  logic [CW-1:0] w_count;
  logic          w_change, w_miss, w_seen_eff;

  phase5_lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_dec   (w_dec),
    .o_zero  (w_zero),
    .o_count (w_count)
  );

  // A key on a window-change cycle belongs to the new window, so it sees a clean key_seen.
  assign w_change   = (time_lock_out != r_prev_win);
  assign w_miss     = (r_prev_win != W_NONE) && w_change && !r_key_seen;
  assign w_seen_eff = w_change ? 1'b0 : r_key_seen;

  // Next-state logic; priority inside TRACK is fail > miss > key > done.
  always_comb begin
    w_state_nxt    = r_state;
    w_key_seen_nxt = r_key_seen;
    w_hit_nxt      = r_hit;
    w_att_nxt      = r_att;
    w_load         = 1'b0;
    w_dec          = 1'b0;
    w_fail_att     = 1'b0;
    case (r_state)
      IDLE: begin
        if (time_lock_out == W1 && r_prev_win != W1) begin
          w_state_nxt    = TRACK;
          w_key_seen_nxt = 1'b0;
          w_hit_nxt      = 3'b000;
        end
      end
      TRACK: begin
        if (phase5_fail) begin
          w_state_nxt = ALARM;
        end else begin
          if (w_change) w_key_seen_nxt = 1'b0;
          if (w_miss) begin
            w_fail_att = 1'b1;
          end else if (key_valid && time_lock_out != W_NONE) begin
            if (!w_seen_eff && key_code == expected_key(time_lock_out, EXPECT_SEQ)) begin
              w_hit_nxt      = r_hit | win_mask(time_lock_out);
              w_key_seen_nxt = 1'b1;
            end else begin
              w_fail_att = 1'b1;
            end
          end
          if (w_fail_att) begin
            w_att_nxt = (r_att == 3'd0) ? 3'd0 : r_att - 3'd1;
            if (w_att_nxt == 3'd0) begin
              w_state_nxt = ALARM;
            end else begin
              w_state_nxt = LOCKOUT;
              w_load      = 1'b1;
              w_hit_nxt   = 3'b000;
            end
          end else if (phase5_done && r_hit == 3'b111) begin
            w_state_nxt = UNLOCKED;
          end
        end
      end
      LOCKOUT: begin
        if (phase5_fail)  w_state_nxt = ALARM;
        else if (w_zero)  w_state_nxt = IDLE;
        else              w_dec       = 1'b1;
      end
      default: ;
    endcase
  end

  // State, tracking registers, and outputs registered off the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_prev_win   <= W_NONE;
      r_key_seen   <= 1'b0;
      r_hit        <= 3'b000;
      r_att        <= 3'(MAX_ATTEMPTS);
      r_key_ready  <= 1'b0;
      r_locked_out <= 1'b0;
      r_unlock     <= 1'b0;
      r_alarm      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_win   <= time_lock_out;
      r_key_seen   <= w_key_seen_nxt;
      r_hit        <= w_hit_nxt;
      r_att        <= w_att_nxt;
      r_key_ready  <= (w_state_nxt == TRACK);
      r_locked_out <= (w_state_nxt == LOCKOUT);
      r_unlock     <= (w_state_nxt == UNLOCKED);
      r_alarm      <= (w_state_nxt == ALARM);
    end
  end

  assign key_ready     = r_key_ready;
  assign window_hit    = r_hit;
  assign attempts_left = r_att;
  assign locked_out    = r_locked_out;
  assign unlock        = r_unlock;
  assign alarm         = r_alarm;

endmodule

// File: tb/tb_phase5_time_lock_verifier.sv
// Directed bench: vector table for the happy path plus hand sequences for corner cases.
module tb_phase5_time_lock_verifier;

  typedef struct packed {
    logic [1:0] tlo;
    logic       done;
    logic       fail;
    logic       kv;
    logic [1:0] kc;
  } in_t;

  typedef struct packed {
    logic       rdy;
    logic [2:0] hit;
    logic [2:0] att;
    logic       lo;
    logic       unl;
    logic       alm;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] time_lock_out = 2'b00;
  logic       phase5_done = 1'b0;
  logic       phase5_fail = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_code = 2'b00;
  logic       key_ready, locked_out, unlock, alarm;
  logic [2:0] window_hit, attempts_left;

  int n_pass = 0;
  int n_total = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  phase5_time_lock_verifier #(
    .MAX_ATTEMPTS   (3),
    .LOCKOUT_CYCLES (16),
    .EXPECT_SEQ     (6'b10_01_11)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .time_lock_out (time_lock_out),
    .phase5_done   (phase5_done),
    .phase5_fail   (phase5_fail),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_ready     (key_ready),
    .window_hit    (window_hit),
    .attempts_left (attempts_left),
    .locked_out    (locked_out),
    .unlock        (unlock),
    .alarm         (alarm)
  );

  function automatic in_t mi(logic [1:0] tlo, logic done, logic fail, logic kv, logic [1:0] kc);
    in_t v;
    v.tlo = tlo; v.done = done; v.fail = fail; v.kv = kv; v.kc = kc;
    return v;
  endfunction

  function automatic out_t mo(logic rdy, logic [2:0] hit, logic [2:0] att,
                              logic lo, logic unl, logic alm);
    out_t v;
    v.rdy = rdy; v.hit = hit; v.att = att; v.lo = lo; v.unl = unl; v.alm = alm;
    return v;
  endfunction

  function automatic out_t cur();
    out_t v;
    v.rdy = key_ready; v.hit = window_hit; v.att = attempts_left;
    v.lo = locked_out; v.unl = unlock; v.alm = alarm;
    return v;
  endfunction

  task automatic chk(input string name, input out_t exp);
    out_t got;
    got = cur();
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got rdy=%b hit=%b att=%0d lo=%b unl=%b alm=%b, want rdy=%b hit=%b att=%0d lo=%b unl=%b alm=%b",
                  name, got.rdy, got.hit, got.att, got.lo, got.unl, got.alm,
                  exp.rdy, exp.hit, exp.att, exp.lo, exp.unl, exp.alm);
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, exp);
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic step(input in_t v);
    time_lock_out = v.tlo; phase5_done = v.done; phase5_fail = v.fail;
    key_valid = v.kv; key_code = v.kc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(mi(2'b00, 0, 0, 0, 2'b00));
    reset_n = 1'b0;
    #2;
    chk("reset_state", mo(0, 3'b000, 3'd3, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Idle the sequencer at 00 until lockout drops; n = extra locked samples seen.
  task automatic wait_lockout(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(mi(2'b00, 0, 0, 0, 2'b00));
      if (!locked_out) break;
      n++;
    end
  endtask

  task automatic run_table(input string tag);
    for (int r = 0; r < tbl.size(); r++) begin
      step(tbl[r].i);
      chk($sformatf("%s_row%0d", tag, r), tbl[r].o);
    end
  endtask

  initial begin
    int n;
    // Happy path: windows 01/10/11 for 5 cycles each, keys 11/01/10, then done.
    for (int c = 0; c < 5; c++)
      tbl.push_back('{mi(2'b01, 0, 0, c == 2, c == 2 ? 2'b11 : 2'b00),
                      mo(1, c >= 2 ? 3'b001 : 3'b000, 3'd3, 0, 0, 0)});
    for (int c = 0; c < 5; c++)
      tbl.push_back('{mi(2'b10, 0, 0, c == 1, c == 1 ? 2'b01 : 2'b00),
                      mo(1, c >= 1 ? 3'b011 : 3'b001, 3'd3, 0, 0, 0)});
    for (int c = 0; c < 5; c++)
      tbl.push_back('{mi(2'b11, 0, 0, c == 1, c == 1 ? 2'b10 : 2'b00),
                      mo(1, c >= 1 ? 3'b111 : 3'b011, 3'd3, 0, 0, 0)});
    tbl.push_back('{mi(2'b00, 0, 0, 0, 2'b00), mo(1, 3'b111, 3'd3, 0, 0, 0)});
    tbl.push_back('{mi(2'b00, 1, 0, 0, 2'b00), mo(0, 3'b111, 3'd3, 0, 1, 0)});
    tbl.push_back('{mi(2'b00, 1, 0, 0, 2'b00), mo(0, 3'b111, 3'd3, 0, 1, 0)});

    // 1: full unlock sequence
    do_reset();
    run_table("unlock");

    // 2: wrong key in window 2 -> 16-cycle lockout, then IDLE and re-entry
    do_reset();
    step(mi(2'b01, 0, 0, 0, 2'b00));
    step(mi(2'b01, 0, 0, 1, 2'b11));
    chk("wrongkey_hit1", mo(1, 3'b001, 3'd3, 0, 0, 0));
    step(mi(2'b10, 0, 0, 0, 2'b00));
    step(mi(2'b10, 0, 0, 1, 2'b00));
    chk("wrongkey_fail", mo(0, 3'b000, 3'd2, 1, 0, 0));
    wait_lockout(n);
    chk_int("lockout_len", n + 1, 16);
    chk("lockout_idle", mo(0, 3'b000, 3'd2, 0, 0, 0));
    step(mi(2'b01, 0, 0, 0, 2'b00));
    chk("reentry", mo(1, 3'b000, 3'd2, 0, 0, 0));

    // 3: no key in window 2; a correct window-3 key on the change cycle is dropped
    do_reset();
    step(mi(2'b01, 0, 0, 0, 2'b00));
    step(mi(2'b01, 0, 0, 1, 2'b11));
    for (int c = 0; c < 3; c++) step(mi(2'b10, 0, 0, 0, 2'b00));
    chk("miss_pre", mo(1, 3'b001, 3'd3, 0, 0, 0));
    step(mi(2'b11, 0, 0, 1, 2'b10));
    chk("miss_fail", mo(0, 3'b000, 3'd2, 1, 0, 0));

    // 4: duplicate key fails; three failed attempts raise alarm
    do_reset();
    step(mi(2'b01, 0, 0, 0, 2'b00));
    step(mi(2'b01, 0, 0, 1, 2'b11));
    step(mi(2'b01, 0, 0, 1, 2'b11));
    chk("dup_fail", mo(0, 3'b000, 3'd2, 1, 0, 0));
    wait_lockout(n);
    step(mi(2'b01, 0, 0, 0, 2'b00));
    step(mi(2'b01, 0, 0, 1, 2'b00));
    chk("att2_fail", mo(0, 3'b000, 3'd1, 1, 0, 0));
    wait_lockout(n);
    step(mi(2'b01, 0, 0, 0, 2'b00));
    step(mi(2'b01, 0, 0, 1, 2'b00));
    chk("att3_alarm", mo(0, 3'b000, 3'd0, 0, 0, 1));
    step(mi(2'b01, 0, 0, 1, 2'b11));
    step(mi(2'b10, 1, 0, 1, 2'b01));
    chk("alarm_sticky", mo(0, 3'b000, 3'd0, 0, 0, 1));

    // 5: sequencer fail in TRACK and in LOCKOUT
    do_reset();
    step(mi(2'b01, 0, 0, 0, 2'b00));
    step(mi(2'b01, 0, 1, 0, 2'b00));
    chk("fail_track", mo(0, 3'b000, 3'd3, 0, 0, 1));
    step(mi(2'b01, 0, 0, 0, 2'b00));
    chk("fail_track_sticky", mo(0, 3'b000, 3'd3, 0, 0, 1));
    do_reset();
    step(mi(2'b01, 0, 0, 0, 2'b00));
    step(mi(2'b01, 0, 0, 1, 2'b00));
    chk("fail_lo_pre", mo(0, 3'b000, 3'd2, 1, 0, 0));
    step(mi(2'b00, 0, 1, 0, 2'b00));
    chk("fail_lockout", mo(0, 3'b000, 3'd2, 0, 0, 1));
    step(mi(2'b00, 0, 0, 0, 2'b00));
    chk("fail_lo_sticky", mo(0, 3'b000, 3'd2, 0, 0, 1));

    // 6: async reset mid-TRACK, then a fresh sequence unlocks
    do_reset();
    step(mi(2'b01, 0, 0, 0, 2'b00));
    step(mi(2'b01, 0, 0, 1, 2'b11));
    chk("midtrack", mo(1, 3'b001, 3'd3, 0, 0, 0));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", mo(0, 3'b000, 3'd3, 0, 0, 0));
    @(negedge clk);
    time_lock_out = 2'b00; key_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_table("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
